// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: deserializer state encoding, comma symbol, lock depth.
package pcie_phy_pkg;
  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} deser_state_t;
  localparam logic [7:0] K28_5          = 8'hBC;
  localparam int         DEF_LOCK_COUNT = 4;
endpackage

// File: rtl/deser_shift_reg.sv
// Serial-in shift register; cand_o is the word including the bit sampled this edge.
module deser_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             bit_i,
  output logic [WIDTH-1:0] cand_o
);
  logic [WIDTH-1:0] sr_q;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign cand_o = {sr_q[WIDTH-2:0], bit_i};
    end else begin : g_lsb
      assign cand_o = {bit_i, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_32f or negedge reset_L)
    if (!reset_L) sr_q <= '0;
    else          sr_q <= cand_o;
endmodule

// File: rtl/serial_paralelo_n.sv
// Serial-to-parallel receiver: comma hunt at any bit offset, lock after LOCK_COUNT aligned commas.
module serial_paralelo_n
  import pcie_phy_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(K28_5),
  parameter int               LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int               MSB_FIRST  = 1,
  localparam int              BCW        = $clog2(LOCK_COUNT+1)
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data2send,
  output logic             valid_out,
  output logic             active,
  output logic [BCW-1:0]   BC_counter
);
  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST   = CW'(WIDTH-1);
  localparam logic [BCW-1:0] BC_MAX = BCW'(LOCK_COUNT);

  deser_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BCW-1:0]   bc_q, bc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             active_q, active_d;
  logic [WIDTH-1:0] cand;
  logic             is_comma, boundary;

  deser_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .bit_i   (data_in),
    .cand_o  (cand)
  );

  assign is_comma = (cand == COMMA);
  assign boundary = (cnt_q == LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bc_d     = bc_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    active_d = active_q;
    case (state_q)
      HUNT: begin
        cnt_d = '0;
        if (is_comma) begin
          bc_d = BCW'(1);
          if (LOCK_COUNT == 1) begin
            state_d  = LOCKED;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        cnt_d = boundary ? '0 : cnt_q + CW'(1);
        if (boundary) begin
          if (is_comma) begin
            bc_d = bc_q + BCW'(1);
            if (bc_q == BC_MAX - BCW'(1)) begin
              state_d  = LOCKED;
              active_d = 1'b1;
            end
          end else begin
            // Misaligned word: drop back and restart the bit-level search next edge.
            bc_d    = '0;
            state_d = HUNT;
          end
        end
      end
      LOCKED: begin
        cnt_d = boundary ? '0 : cnt_q + CW'(1);
        if (boundary) begin
          data_d  = cand;
          valid_d = !is_comma;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset_L)
    if (!reset_L) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      bc_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bc_q     <= bc_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end

  assign data2send  = data_q;
  assign valid_out  = valid_q;
  assign active     = active_q;
  assign BC_counter = bc_q;
endmodule

// File: tb/tb_serial_paralelo_n.sv
// Bench for serial_paralelo_n: word-level reference model, two parameterisations.
module tb_serial_paralelo_n;
  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       di1 = 1'b0, di2 = 1'b0;
  logic [7:0] d1;
  logic [9:0] d2;
  logic       v1, v2, a1, a2;
  logic [2:0] bc1;
  logic [1:0] bc2;

  int n_assert = 0, n_fail = 0, pulses = 0;

  // per-instance configuration and model state
  int         W [2] = '{8, 10};
  logic [9:0] CM[2] = '{10'h0BC, 10'h17C};
  int         LC[2] = '{4, 2};
  int         MF[2] = '{1, 0};
  logic [9:0] m_data[2];
  logic       m_vld[2], m_act[2];
  int         m_bc[2];

  always #5 clk = ~clk;

  serial_paralelo_n dut1 (
    .clk_32f(clk), .reset_L(reset_L), .data_in(di1),
    .data2send(d1), .valid_out(v1), .active(a1), .BC_counter(bc1));

  serial_paralelo_n #(.WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(2), .MSB_FIRST(0)) dut2 (
    .clk_32f(clk), .reset_L(reset_L), .data_in(di2),
    .data2send(d2), .valid_out(v2), .active(a2), .BC_counter(bc2));

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_data[k] = '0; m_vld[k] = 1'b0; m_act[k] = 1'b0; m_bc[k] = 0;
    end
  endtask

  // One complete word as framed by the sender.
  task automatic model_word(input int k, input logic [9:0] w);
    if (m_act[k]) begin
      m_data[k] = w;
      m_vld[k]  = (w != CM[k]);
    end else begin
      m_vld[k] = 1'b0;
      if (w == CM[k]) begin
        if (m_bc[k] < LC[k]) m_bc[k]++;
        if (m_bc[k] == LC[k]) m_act[k] = 1'b1;
      end else begin
        m_bc[k] = 0;
      end
    end
  endtask

  task automatic check(input int k, input string tag);
    logic [9:0] d; logic v, a; logic [3:0] bc;
    if (k == 0) begin d = {2'b00, d1}; v = v1; a = a1; bc = {1'b0, bc1}; end
    else        begin d = d2;          v = v2; a = a2; bc = {2'b00, bc2}; end
    n_assert++;
    assert (d === m_data[k]) else begin n_fail++; $error("FAIL %s.data2send got %h exp %h", tag, d, m_data[k]); end
    n_assert++;
    assert (v === m_vld[k]) else begin n_fail++; $error("FAIL %s.valid_out got %b exp %b", tag, v, m_vld[k]); end
    n_assert++;
    assert (a === m_act[k]) else begin n_fail++; $error("FAIL %s.active got %b exp %b", tag, a, m_act[k]); end
    n_assert++;
    assert (bc === 4'(m_bc[k])) else begin n_fail++; $error("FAIL %s.BC_counter got %0d exp %0d", tag, bc, m_bc[k]); end
  endtask

  task automatic drive(input int k, input logic b);
    if (k == 0) di1 = b; else di2 = b;
  endtask

  task automatic send_bit(input int k, input logic b, input string tag);
    drive(k, b);
    @(posedge clk); #1;
    m_vld[k] = 1'b0;
    check(k, tag);
  endtask

  task automatic send_word(input int k, input logic [9:0] w, input string tag);
    logic b;
    for (int i = 0; i < W[k]; i++) begin
      b = (MF[k] != 0) ? w[W[k]-1-i] : w[i];
      drive(k, b);
      @(posedge clk); #1;
      if (i == W[k]-1) model_word(k, w);
      else             m_vld[k] = 1'b0;
      check(k, tag);
      if (k == 0 && v1 === 1'b1) pulses++;
    end
  endtask

  initial begin
    logic [9:0] w;
    model_reset();

    // reset held with random serial input
    for (int i = 0; i < 3; i++) begin
      di1 = 1'($urandom); di2 = 1'($urandom);
      @(posedge clk); #1;
      check(0, "rst1"); check(1, "rst2");
    end
    di1 = 1'b0; di2 = 1'b0;
    reset_L = 1'b1;

    // lock at offset 3, then first data word
    for (int i = 0; i < 3; i++) send_bit(0, 1'($urandom), "garbage");
    for (int i = 0; i < 4; i++) send_word(0, 10'h0BC, "preamble");
    send_word(0, 10'h05A, "word5A");

    // idle fill between data words
    send_word(0, 10'h011, "fill11");
    send_word(0, 10'h0BC, "fillBC");
    send_word(0, 10'h022, "fill22");

    // back-to-back random data
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      do w = 10'($urandom_range(0, 255)); while (w == 10'h0BC);
      send_word(0, w, "rand8");
    end
    n_assert++;
    assert (pulses == 16) else begin n_fail++; $error("FAIL pulse_count got %0d exp 16", pulses); end

    // asynchronous reset mid-word while locked
    for (int i = 0; i < 3; i++) send_bit(0, 1'($urandom), "midword");
    #2 reset_L = 1'b0;
    #1 model_reset();
    check(0, "async_rst1"); check(1, "async_rst2");
    @(posedge clk); @(posedge clk); #1;
    check(0, "rst_hold");
    di1 = 1'b0;
    reset_L = 1'b1;

    // broken preamble: counter clears at 3C, lock only after final four commas
    for (int i = 0; i < 3; i++) send_bit(0, 1'($urandom), "garbage2");
    send_word(0, 10'h0BC, "brk_bc");
    send_word(0, 10'h0BC, "brk_bc");
    send_word(0, 10'h03C, "brk_3c");
    for (int i = 0; i < 4; i++) send_word(0, 10'h0BC, "brk_lock");
    do w = 10'($urandom_range(0, 255)); while (w == 10'h0BC);
    send_word(0, w, "brk_data");

    // LSB-first, 10-bit instance
    reset_L = 1'b0;
    #1 model_reset();
    @(posedge clk); #1;
    check(1, "rst2b");
    reset_L = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1, 1'($urandom), "garbage10");
    send_word(1, 10'h17C, "pre10");
    send_word(1, 10'h17C, "pre10");
    send_word(1, 10'h2A5, "word2A5");
    for (int i = 0; i < 4; i++) begin
      do w = 10'($urandom_range(0, 1023)); while (w == 10'h17C);
      send_word(1, w, "rand10");
    end
    send_word(1, 10'h17C, "idle10");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_paralelo_n.md
# serial_paralelo_n

Parametrised, single-clock successor to the receive-side serial-to-parallel converter of the PCIe physical-layer datapath. Samples one serial bit per `clk_32f` edge, hunts for a comma word at any bit offset, and locks word alignment after a run of consecutive commas. Delivers aligned parallel words with a valid flag to the byte-striping/unstriping stage downstream. The word boundary comes from an internal bit counter, so no divided clock (`clk_4f`) is needed.

## Interface
Parameters:
- `WIDTH`, 8: parallel word width in bits (≥4).
- `COMMA`, 8'hBC: alignment word (`WIDTH` bits).
- `LOCK_COUNT`, 4: consecutive aligned commas required to declare `active`.
- `MSB_FIRST`, 1: 1 means first serial bit lands in `data2send[WIDTH-1]`; 0 means it lands in bit 0.

Ports:
- `clk_32f`  in  1  bit clock. The only clock.
- `reset_L`  in  1  asynchronous, active-low reset.
- `data_in`  in  1  serial bit, sampled on rising `clk_32f`.
- `data2send`  out  WIDTH  last aligned word, registered.
- `valid_out`  out  1  `data2send` updated this cycle with a non-comma word while active.
- `active`  out  1  alignment locked.
- `BC_counter`  out  $clog2(LOCK_COUNT+1)  consecutive aligned commas seen, saturating at LOCK_COUNT.

## Operation
- Shift register `sr[WIDTH-1:0]` takes `data_in` every edge.
  - MSB_FIRST=1: `sr <= {sr[WIDTH-2:0], data_in}`.
  - MSB_FIRST=0: `sr <= {data_in, sr[WIDTH-1:1]}`.
- "Candidate word" is the value of `sr` including the bit sampled at the current edge.
- States: HUNT, ALIGN, LOCKED. Reset state is HUNT.
  - HUNT: compare the candidate word against COMMA every cycle.
    - On match: bit counter cleared to 0, `BC_counter`=1, go to ALIGN. If LOCK_COUNT=1, go directly to LOCKED instead.
  - ALIGN: evaluate only on word boundaries, i.e. bit counter = WIDTH-1.
    - Comma: `BC_counter`+1. On reaching LOCK_COUNT, go to LOCKED.
    - Non-comma: `BC_counter`=0, go to HUNT. The bit-level search restarts on the next edge.
  - LOCKED: `active`=1.
    - Every word boundary: `data2send` <= candidate word.
    - `valid_out`=1 for one cycle if the word ≠ COMMA. Commas are idle fill: `data2send` is still updated, but `valid_out`=0.
    - LOCKED is left only by reset. `BC_counter` holds LOCK_COUNT.
- Bit counter runs 0..WIDTH-1 and wraps. It is free-running in ALIGN/LOCKED and held at 0 in HUNT.
- `data2send` is not updated in HUNT/ALIGN. It keeps its value, or 0 after reset.
- Reset values: `data2send`=0, `valid_out`=0, `active`=0, `BC_counter`=0, `sr`=0, bit counter=0, state=HUNT.

## Timing
- Latency: the last bit of a word is sampled at edge N. `data2send`/`valid_out` are visible after edge N, so all outputs are registered and there is 1 cycle of latency from that bit to the word.
- `valid_out` is a single-cycle pulse, at most once every WIDTH cycles. It is never asserted while `active`=0.
- `active` rises after the edge that completes the LOCK_COUNT-th consecutive comma. The lock word itself is a comma, so `valid_out` stays 0 on that edge.
- Comma match on the same edge as the ALIGN → HUNT drop: the dropping word is judged only at the boundary. Re-search starts one edge later. A comma straddling the drop is missed and is caught at its next occurrence.
- Reset asserted mid-word: all state clears immediately and asynchronously. Deassertion is synchronised externally. First sample is on the first rising edge with `reset_L`=1.
- `BC_counter` saturates; it never wraps.

## Structure
- Shared package `pcie_phy_pkg`:
  - state encoding `deser_state_t` {HUNT, ALIGN, LOCKED}
  - default comma `K28_5 = 8'hBC`
  - default `LOCK_COUNT`
- One sub-module, `deser_shift_reg`: shift register plus MSB_FIRST handling, exposing the candidate word combinationally.
- Bit counter, FSM and output registers live in `serial_paralelo_n`.

## Test plan
- Reset: hold `reset_L`=0 for 3 cycles with random `data_in` → all outputs 0. Assert reset mid-word while LOCKED → `active`/`BC_counter`/`valid_out` drop to 0 in the same cycle.
- Lock at offset 3: 3 garbage bits, then BC,BC,BC,BC, then 8'h5A, MSB first → `BC_counter` reads 1,2,3,4; `active`=1 after the 32nd aligned bit; `data2send`=8'h5A with one `valid_out` pulse 8 cycles later.
- Broken preamble: BC,BC,8'h3C,BC,BC,BC,BC → `BC_counter` returns to 0 at the 8'h3C boundary; lock occurs only after the final four BCs.
- Idle fill: while LOCKED send 8'h11,BC,8'h22 → `data2send` = 11, BC, 22; `valid_out` pulses only for 11 and 22.
- MSB_FIRST=0, WIDTH=10, COMMA=10'h17C, LOCK_COUNT=2 → lock after two commas; the next word 10'h2A5 appears with bit 0 = first serial bit.
- Back-to-back data: 16 random words after lock → exactly 16 `valid_out` pulses, spaced 8 cycles apart, with matching values.
